// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: steps the shared datapath through fetch, decode,
// execute, memory and writeback, waits on memory handshakes, counts retirements.
module rv32i_multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_code,
   input  logic        i_ready,
   input  logic        d_ready,
   output logic        i_req,
   output logic        ir_en,
   output logic        pc_en,
   output logic        reg_wr_en,
   output logic [3:0]  alu_controls,
   output logic        aluSrcMuxSel,
   output logic [2:0]  RegWdataSel,
   output logic        branch,
   output logic        jal,
   output logic        jalr,
   output logic        d_req,
   output logic        d_wr_en,
   output logic        halted,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
   } state_t;

   state_t      state;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        f7b5;
   logic        is_r, is_i, is_il, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
   logic        legal;
   logic        decoding;
   logic        unused_fields;

   assign opcode   = instr_code[6:0];
   assign funct3   = instr_code[14:12];
   assign f7b5     = instr_code[30];
   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_il    = (opcode == 7'b0000011);
   assign is_s     = (opcode == 7'b0100011);
   assign is_b     = (opcode == 7'b1100011);
   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_jalr  = (opcode == 7'b1100111);
   assign legal    = is_r | is_i | is_il | is_s | is_b | is_lui | is_auipc | is_jal | is_jalr;
   assign decoding = (state == S_DECODE) || (state == S_EXECUTE) ||
                     (state == S_MEM) || (state == S_WB);

   // Register indices and immediates belong to the datapath, not the controller.
   assign unused_fields = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

   // Strobes are gated by reset so an abort produces no pulse while reset is held.
   always_comb begin
      i_req        = 1'b0;
      ir_en        = 1'b0;
      pc_en        = 1'b0;
      reg_wr_en    = 1'b0;
      branch       = 1'b0;
      d_req        = 1'b0;
      d_wr_en      = 1'b0;
      halted       = 1'b0;
      alu_controls = 4'b0000;
      aluSrcMuxSel = 1'b0;
      RegWdataSel  = 3'd0;
      jal          = 1'b0;
      jalr         = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               i_req = 1'b1;
               ir_en = i_ready;
            end
            S_EXECUTE: begin
               branch = is_b;
               pc_en  = is_b;
            end
            S_MEM: begin
               d_req   = 1'b1;
               d_wr_en = is_s;
               pc_en   = is_s & d_ready;
            end
            S_WB: begin
               reg_wr_en = 1'b1;
               pc_en     = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
         if (decoding) begin
            if (is_r)
               alu_controls = {f7b5, funct3};
            else if (is_i)
               alu_controls = {(funct3 == 3'b101) & f7b5, funct3};
            else if (is_b)
               alu_controls = {1'b0, funct3};
            aluSrcMuxSel = is_i | is_il | is_s | is_jalr;
            if (is_il)
               RegWdataSel = 3'd1;
            else if (is_lui)
               RegWdataSel = 3'd2;
            else if (is_auipc)
               RegWdataSel = 3'd3;
            else if (is_jal || is_jalr)
               RegWdataSel = 3'd4;
            jal  = is_jal | is_jalr;
            jalr = is_jalr;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_FETCH;
         instret <= 32'd0;
      end else begin
         if (pc_en)
            instret <= instret + 32'd1;
         case (state)
            S_FETCH:   if (i_ready) state <= S_DECODE;
            S_DECODE:  state <= legal ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
               if (is_b)
                  state <= S_FETCH;
               else if (is_il || is_s)
                  state <= S_MEM;
               else
                  state <= S_WB;
            end
            S_MEM:     if (d_ready) state <= is_s ? S_FETCH : S_WB;
            S_WB:      state <= S_FETCH;
            S_HALT:    state <= S_HALT;
            default:   state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: directed vector table, randomized instructions
// against an instruction-level model, and hand sequences for halt and reset abort.
module tb_rv32i_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_code;
   logic        i_ready, d_ready;
   logic        i_req, ir_en, pc_en, reg_wr_en;
   logic [3:0]  alu_controls;
   logic        aluSrcMuxSel;
   logic [2:0]  RegWdataSel;
   logic        branch, jal, jalr, d_req, d_wr_en, halted;
   logic [31:0] instret;

   rv32i_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .instr_code(instr_code),
      .i_ready(i_ready), .d_ready(d_ready),
      .i_req(i_req), .ir_en(ir_en), .pc_en(pc_en), .reg_wr_en(reg_wr_en),
      .alu_controls(alu_controls), .aluSrcMuxSel(aluSrcMuxSel),
      .RegWdataSel(RegWdataSel), .branch(branch), .jal(jal), .jalr(jalr),
      .d_req(d_req), .d_wr_en(d_wr_en), .halted(halted), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cycles, ir, pc, wr, dreq, br, ireq;
      logic       dwr, done, fetch_dec;
      logic [3:0] alu;
      logic       src;
      logic [2:0] sel;
      logic       j, jr;
   } obs_t;

   typedef struct {
      logic [31:0] ins;
      int          iw, dw;
      int          exp_cycles;
      logic [3:0]  exp_alu;
      logic [2:0]  exp_sel;
   } vec_t;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_instret = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Instruction-level expectations straight from the opcode rules.
   function automatic obs_t model(input logic [31:0] ins, input int iw, input int dw);
      obs_t       e;
      logic [6:0] op  = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      logic       b30 = ins[30];
      bit r  = (op == 7'h33), i  = (op == 7'h13), il = (op == 7'h03), s = (op == 7'h23);
      bit b  = (op == 7'h63), lu = (op == 7'h37), au = (op == 7'h17);
      bit jl = (op == 7'h6F), jr = (op == 7'h67);
      e = '{default: 0};
      e.cycles = (b ? 3 : (il ? 5 : 4)) + iw + ((il || s) ? dw : 0);
      e.ir     = 1;
      e.pc     = 1;
      e.ireq   = 1 + iw;
      e.wr     = (b || s) ? 0 : 1;
      e.dreq   = (il || s) ? 1 + dw : 0;
      e.dwr    = s;
      e.br     = b ? 1 : 0;
      e.done   = 1'b1;
      if (r)      e.alu = {b30, f3};
      else if (i) e.alu = {(f3 == 3'd5) ? b30 : 1'b0, f3};
      else if (b) e.alu = {1'b0, f3};
      e.src = i || il || s || jr;
      e.sel = il ? 3'd1 : lu ? 3'd2 : au ? 3'd3 : (jl || jr) ? 3'd4 : 3'd0;
      e.j   = jl || jr;
      e.jr  = jr;
      return e;
   endfunction

   // Runs one instruction from FETCH to its pc_en; entered and left just after a posedge.
   task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, output obs_t o);
      int icnt = 0;
      int dcnt = 0;
      o = '{default: 0};
      instr_code = ins;
      for (int c = 0; c < 60 && !o.done; c++) begin
         i_ready = (icnt >= iw);
         d_ready = (dcnt >= dw);
         @(negedge clk);
         o.cycles++;
         if (i_req) begin
            icnt++;
            o.ireq++;
            if (alu_controls != 0 || aluSrcMuxSel || RegWdataSel != 0 || jal || jalr || branch)
               o.fetch_dec = 1'b1;
         end
         if (d_req) dcnt++;
         o.ir   += int'(ir_en);
         o.pc   += int'(pc_en);
         o.wr   += int'(reg_wr_en);
         o.dreq += int'(d_req);
         o.br   += int'(branch);
         if (d_wr_en) o.dwr = 1'b1;
         if (pc_en) begin
            o.done = 1'b1;
            o.alu  = alu_controls;
            o.src  = aluSrcMuxSel;
            o.sel  = RegWdataSel;
            o.j    = jal;
            o.jr   = jalr;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare(input string tag, input obs_t o, input obs_t e);
      check({tag, " done"},      o.done, e.done);
      check({tag, " cycles"},    o.cycles, e.cycles);
      check({tag, " ir_en"},     o.ir, e.ir);
      check({tag, " pc_en"},     o.pc, e.pc);
      check({tag, " reg_wr"},    o.wr, e.wr);
      check({tag, " i_req"},     o.ireq, e.ireq);
      check({tag, " d_req"},     o.dreq, e.dreq);
      check({tag, " d_wr_en"},   o.dwr, e.dwr);
      check({tag, " branch"},    o.br, e.br);
      check({tag, " alu"},       o.alu, e.alu);
      check({tag, " src"},       o.src, e.src);
      check({tag, " wsel"},      o.sel, e.sel);
      check({tag, " jal"},       o.j, e.j);
      check({tag, " jalr"},      o.jr, e.jr);
      check({tag, " fetch_dec"}, o.fetch_dec, 1'b0);
      exp_instret = exp_instret + 32'd1;
      check({tag, " instret"},   instret, exp_instret);
   endtask

   initial begin
      vec_t        tbl[14];
      obs_t        o, e;
      logic [6:0]  ops[9];
      logic [31:0] r;
      int          waited;
      int          bad;

      tbl[0]  = '{32'h002081B3, 0, 0, 4, 4'b0000, 3'd0}; // ADD
      tbl[1]  = '{32'h402081B3, 0, 0, 4, 4'b1000, 3'd0}; // SUB
      tbl[2]  = '{32'h4030D293, 0, 0, 4, 4'b1101, 3'd0}; // SRAI
      tbl[3]  = '{32'h40008193, 0, 0, 4, 4'b0000, 3'd0}; // ADDI, bit30 in imm
      tbl[4]  = '{32'h0050A193, 0, 0, 4, 4'b0010, 3'd0}; // SLTI
      tbl[5]  = '{32'h00802203, 0, 2, 7, 4'b0000, 3'd1}; // LW, 2 wait
      tbl[6]  = '{32'h00202223, 0, 0, 4, 4'b0000, 3'd0}; // SW
      tbl[7]  = '{32'h00202223, 0, 1, 5, 4'b0000, 3'd0}; // SW, 1 wait
      tbl[8]  = '{32'h00209463, 0, 0, 3, 4'b0001, 3'd0}; // BNE
      tbl[9]  = '{32'h000280E7, 0, 0, 4, 4'b0000, 3'd4}; // JALR
      tbl[10] = '{32'h008000EF, 0, 0, 4, 4'b0000, 3'd4}; // JAL
      tbl[11] = '{32'h123452B7, 0, 0, 4, 4'b0000, 3'd2}; // LUI
      tbl[12] = '{32'h00001297, 0, 0, 4, 4'b0000, 3'd3}; // AUIPC
      tbl[13] = '{32'h002081B3, 3, 0, 7, 4'b0000, 3'd0}; // ADD, 3 fetch waits
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

      reset = 1'b1; instr_code = 32'h0; i_ready = 1'b0; d_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset outputs",
            {i_req, ir_en, pc_en, reg_wr_en, alu_controls, aluSrcMuxSel, RegWdataSel,
             branch, jal, jalr, d_req, d_wr_en, halted}, 0);
      check("reset instret", instret, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("i_req after reset", i_req, 1'b1);
      @(posedge clk); #1;

      foreach (tbl[k]) begin
         run_instr(tbl[k].ins, tbl[k].iw, tbl[k].dw, o);
         check($sformatf("tbl%0d cycles", k), o.cycles, tbl[k].exp_cycles);
         check($sformatf("tbl%0d alu", k), o.alu, tbl[k].exp_alu);
         check($sformatf("tbl%0d wsel", k), o.sel, tbl[k].exp_sel);
         compare($sformatf("tbl%0d", k), o, model(tbl[k].ins, tbl[k].iw, tbl[k].dw));
      end

      for (int n = 0; n < 40; n++) begin
         int iw = $urandom_range(0, 3);
         int dw = $urandom_range(0, 3);
         r = $urandom();
         r[6:0] = ops[$urandom_range(0, 8)];
         run_instr(r, iw, dw, o);
         compare($sformatf("rnd%0d %08h", n, r), o, model(r, iw, dw));
      end

      // Reset asserted while a load waits in MEM.
      instr_code = 32'h00802203; i_ready = 1'b1; d_ready = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!d_req && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("reached MEM", d_req, 1'b1);
      #2 reset = 1'b1;
      #1 check("abort strobes", {d_req, pc_en, reg_wr_en, i_req, ir_en}, 0);
      check("abort instret", instret, 32'd0);
      @(negedge clk);
      check("abort held", {d_req, pc_en, reg_wr_en, i_req}, 0);
      @(posedge clk); #1;
      reset = 1'b0; d_ready = 1'b1; i_ready = 1'b0;
      @(negedge clk);
      check("abort back to FETCH", {i_req, d_req}, 2'b10);
      exp_instret = 32'd0;
      @(posedge clk); #1;

      // Illegal opcode: fetch, decode, then stuck in HALT.
      instr_code = 32'h0000007F; i_ready = 1'b1; d_ready = 1'b1;
      @(negedge clk);
      check("illegal ir_en", ir_en, 1'b1);
      @(negedge clk);
      check("illegal decode not halted", halted, 1'b0);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("halted c%0d", c), halted, 1'b1);
         bad += int'(i_req | ir_en | pc_en | reg_wr_en | d_req | d_wr_en | branch);
      end
      check("halt strobes", bad, 0);
      check("halt instret", instret, 32'd0);
      #2 reset = 1'b1;
      #1 check("reset exits halt", halted, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(32'h002081B3, 0, 0, o);
      compare("post-halt ADD", o, model(32'h002081B3, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle control unit for the RV32I core: sequences the shared datapath (PC register, instruction register, register file, ALU, immediate extender, result mux) through fetch/decode/execute/memory/writeback states. Handshakes with instruction and data memories that may insert wait states. Counts retired instructions. Halts on an unsupported opcode.

## Interface
Parameters: none.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr_code  in  32  instruction register output; stable from DECODE until return to FETCH
- i_ready  in  1  instruction memory has instruction valid this cycle
- d_ready  in  1  data memory access completes this cycle
- i_req  out  1  instruction fetch request
- ir_en  out  1  instruction register load strobe
- pc_en  out  1  PC register update strobe
- reg_wr_en  out  1  register file write enable
- alu_controls  out  4  ALU operation code
- aluSrcMuxSel  out  1  ALU operand B select: 0 rs2, 1 immediate
- RegWdataSel  out  3  write-back select: 0 ALU, 1 load data, 2 imm (LUI), 3 PC+imm (AUIPC), 4 PC+4 (JAL/JALR)
- branch  out  1  conditional branch qualifier for PC mux
- jal  out  1  unconditional jump, PC mux selects imm target
- jalr  out  1  jump base select rs1
- d_req  out  1  data memory request
- d_wr_en  out  1  data memory write (valid with d_req)
- halted  out  1  controller in HALT
- instret  out  32  retired instruction count, wraps modulo 2^32

## Operation
- Opcodes: R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Any other opcode is illegal.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - i_req=1.
  - If i_ready=1: ir_en=1 and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Illegal opcode goes to HALT; any legal opcode goes to EXECUTE.
- EXECUTE:
  - R/I/LUI/AUIPC/JAL/JALR go to WB.
  - IL/S go to MEM.
  - B: branch=1, pc_en=1, retire, go to FETCH.
- MEM:
  - d_req=1; d_wr_en=1 for S.
  - Stay in MEM while d_ready=0.
  - On d_ready, S: pc_en=1, retire, go to FETCH.
  - On d_ready, IL: go to WB.
- WB: reg_wr_en=1, pc_en=1, retire, go to FETCH.
- HALT: all strobes 0, halted=1. Exit only by reset.
- Decoded fields are driven combinationally from instr_code in DECODE, EXECUTE, MEM and WB: alu_controls, aluSrcMuxSel, RegWdataSel, jal, jalr. They are 0 in FETCH and HALT.
  - branch is asserted only in EXECUTE.
  - jal=1 for JAL and JALR. jalr=1 for JALR only.
- alu_controls encoding:
  - R: {funct7[5], funct3}.
  - I: {funct3==101 ? funct7[5] : 0, funct3}.
  - B: {0, funct3}; the ALU branch compare uses bits [2:0].
  - All others: 0000 (ADD).
- aluSrcMuxSel is 1 for I, IL, S and JALR, and 0 otherwise.
- RegWdataSel by type: R/I 0, IL 1, LUI 2, AUIPC 3, JAL/JALR 4.
- Retire means instret increments by 1 in the same cycle as pc_en.

## Timing
- Reset (async): state=FETCH, instret=0, all outputs 0.
  - i_req becomes 1 after reset deasserts because FETCH decodes it.
  - Reset mid-instruction aborts with no reg_wr_en, pc_en or d_req pulse after assertion.
- Minimum latency (i_ready/d_ready high on first request), FETCH to next FETCH:
  - B: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR/S: 4 cycles.
  - IL: 5 cycles.
- Each cycle of i_ready or d_ready low adds exactly one cycle. Request outputs are held high while waiting.
- ir_en, pc_en and reg_wr_en are single-cycle pulses, at most once per instruction.
- d_req is held until the d_ready cycle inclusive and drops the following cycle.
- The branch target or PC+4 is selected by the datapath; the controller asserts pc_en for both outcomes.
- instret wraps from 0xFFFFFFFF to 0.

## Test plan
- ADD x3,x1,x2 (0x002081B3), readies tied high → states FETCH→DECODE→EXECUTE→WB over 4 cycles; WB: reg_wr_en=1, pc_en=1, RegWdataSel=0, alu_controls=0000; instret 0→1.
- SUB x3,x1,x2 (0x402081B3) → alu_controls=1000. SRAI x5,x1,3 (0x4030D293) → alu_controls=1101, aluSrcMuxSel=1.
- LW x4,8(x0) (0x00802203) with d_ready low for 2 cycles → d_req high 3 cycles with d_wr_en=0; WB RegWdataSel=1; total 7 cycles.
- SW x2,4(x0) (0x00202223) → MEM with d_req=1 and d_wr_en=1; pc_en on the d_ready cycle; reg_wr_en never asserted.
- BNE x1,x2,+8 (0x00209463) → EXECUTE: branch=1, pc_en=1, alu_controls=0001; next cycle FETCH; 3 cycles total.
- JALR x1,0(x5) (0x000280E7) → jal=1, jalr=1, RegWdataSel=4. Illegal opcode 0x0000007F → DECODE→HALT, halted=1, no strobes. Reset asserted mid-MEM → FETCH, instret=0.
